// File: rtl/s526n_harness_pkg.sv
// Shared types and constants for the s526n response-compaction harness.
// Covers the FSM state encoding, the default MISR polynomial and seed, and the RESP bit order.
package s526n_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // Bit positions of the s526n primary outputs inside RESP.
    localparam int RESP_G147 = 5;
    localparam int RESP_G148 = 4;
    localparam int RESP_G198 = 3;
    localparam int RESP_G199 = 2;
    localparam int RESP_G213 = 1;
    localparam int RESP_G214 = 0;

endpackage

// File: rtl/misr_step.sv
// Combinational single-step MISR update: shift, conditional polynomial feedback, XOR in the response.
// It is kept standalone so that a stimulus LFSR can reuse it with resp tied to zero.
module misr_step #(
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [5:0]       resp,
    output logic [SIG_W-1:0] nxt
);

    logic [SIG_W-1:0] fb;

    always_comb begin
        fb  = sig[SIG_W-1] ? POLY : '0;
        nxt = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);
    end

endmodule

// File: rtl/s526n_resp_misr.sv
// Folds the six s526n primary outputs into a MISR over a programmed number of qualified cycles.
// The final signature is then offered through a valid/ready handshake.
module s526n_resp_misr
    import s526n_harness_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
    parameter int               LEN_W = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [5:0]       resp,
    input  logic             resp_vld,
    output logic             busy,
    output logic [SIG_W-1:0] sig,
    output logic             sig_vld,
    input  logic             sig_rdy,
    output logic [LEN_W-1:0] cnt
);

    state_t           state, state_nxt;
    logic [SIG_W-1:0] sig_nxt, sig_step;
    logic [LEN_W-1:0] cnt_nxt, cnt_inc;
    logic [LEN_W-1:0] len_q, len_nxt;

    misr_step #(
        .SIG_W(SIG_W),
        .POLY (POLY)
    ) u_step (
        .sig (sig),
        .resp(resp),
        .nxt (sig_step)
    );

    assign cnt_inc = cnt + LEN_W'(1);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks every other transition in RUN and HOLD; a capture coinciding with it is dropped.
    always_comb begin
        state_nxt = state;
        sig_nxt   = sig;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sig_nxt   = SEED;
                    cnt_nxt   = '0;
                    len_nxt   = len;
                    state_nxt = (len == '0) ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (resp_vld) begin
                    sig_nxt = sig_step;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (abort || sig_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sig   <= SEED;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            sig   <= sig_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_nxt;
        end
    end

    assign busy    = (state == ST_RUN) || (state == ST_HOLD);
    assign sig_vld = (state == ST_HOLD);

endmodule

// File: tb/tb_s526n_resp_misr.sv
// Directed bench for s526n_resp_misr with hand-computed signatures for POLY=16'h1021, SEED=16'hFFFF.
module tb_s526n_resp_misr;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] len = '0;
    logic [5:0]  resp = '0;
    logic        resp_vld = 1'b0;
    logic        busy;
    logic [15:0] sig;
    logic        sig_vld;
    logic        sig_rdy = 1'b0;
    logic [15:0] cnt;

    int total = 0;
    int bad = 0;

    s526n_resp_misr dut (
        .ck      (ck),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .resp    (resp),
        .resp_vld(resp_vld),
        .busy    (busy),
        .sig     (sig),
        .sig_vld (sig_vld),
        .sig_rdy (sig_rdy),
        .cnt     (cnt)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({busy, sig_vld, sig, cnt} !== {1'b0, 1'b0, 16'hFFFF, 16'h0000}) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got busy=%b vld=%b sig=%h cnt=%0d want busy=0 vld=0 sig=ffff cnt=0",
                         i, busy, sig_vld, sig, cnt);
            end
        end
    endtask

    task automatic test_len1(input logic [5:0] r, input logic [15:0] exp_sig);
        start = 1'b1;
        len   = 16'd1;
        tick();
        start = 1'b0;
        len   = 16'd9;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b1, 1'b0, 16'hFFFF, 16'h0000}) begin
            bad++;
            $display("FAIL len1_start: got busy=%b vld=%b sig=%h cnt=%0d want busy=1 vld=0 sig=ffff cnt=0",
                     busy, sig_vld, sig, cnt);
        end
        resp_vld = 1'b1;
        resp     = r;
        tick();
        resp_vld = 1'b0;
        resp     = 6'h2A;
        total++;
        if ({sig_vld, sig, cnt} !== {1'b1, exp_sig, 16'd1}) begin
            bad++;
            $display("FAIL len1_sig resp=%h: got vld=%b sig=%h cnt=%0d want vld=1 sig=%h cnt=1",
                     r, sig_vld, sig, cnt, exp_sig);
        end
        sig_rdy = 1'b1;
        tick();
        sig_rdy = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b0, 1'b0, exp_sig, 16'd1}) begin
            bad++;
            $display("FAIL len1_xfer: got busy=%b vld=%b sig=%h cnt=%0d want busy=0 vld=0 sig=%h cnt=1",
                     busy, sig_vld, sig, cnt, exp_sig);
        end
    endtask

    task automatic test_len0();
        start = 1'b1;
        len   = 16'd0;
        tick();
        start = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b1, 1'b1, 16'hFFFF, 16'h0000}) begin
            bad++;
            $display("FAIL len0_hold: got busy=%b vld=%b sig=%h cnt=%0d want busy=1 vld=1 sig=ffff cnt=0",
                     busy, sig_vld, sig, cnt);
        end
        sig_rdy = 1'b1;
        tick();
        sig_rdy = 1'b0;
        total++;
        if ({busy, sig_vld} !== 2'b00) begin
            bad++;
            $display("FAIL len0_xfer: got busy=%b vld=%b want busy=0 vld=0", busy, sig_vld);
        end
    endtask

    task automatic test_gapped();
        logic [6:0]  pat;
        logic [5:0]  data [4];
        int          k;
        pat  = 7'b1011001;
        data = '{6'h01, 6'h02, 6'h04, 6'h08};
        k    = 0;
        start = 1'b1;
        len   = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            resp_vld = pat[6-i];
            resp     = resp_vld ? data[k] : 6'h3F;
            if (resp_vld) k++;
            tick();
            if (i == 5) begin
                total++;
                if ({sig_vld, cnt} !== {1'b0, 16'd3}) begin
                    bad++;
                    $display("FAIL gap_mid: got vld=%b cnt=%0d want vld=0 cnt=3", sig_vld, cnt);
                end
            end
        end
        resp_vld = 1'b0;
        total++;
        if ({sig_vld, sig, cnt} !== {1'b1, 16'h0E1F, 16'd4}) begin
            bad++;
            $display("FAIL gap_final: got vld=%b sig=%h cnt=%0d want vld=1 sig=0e1f cnt=4",
                     sig_vld, sig, cnt);
        end
        // Stall the consumer while poking resp and start; nothing may move.
        resp_vld = 1'b1;
        resp     = 6'h15;
        start    = 1'b1;
        len      = 16'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({sig_vld, sig, cnt} !== {1'b1, 16'h0E1F, 16'd4}) begin
                bad++;
                $display("FAIL gap_stall[%0d]: got vld=%b sig=%h cnt=%0d want vld=1 sig=0e1f cnt=4",
                         i, sig_vld, sig, cnt);
            end
        end
        resp_vld = 1'b0;
        start    = 1'b0;
        sig_rdy  = 1'b1;
        tick();
        sig_rdy = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b0, 1'b0, 16'h0E1F, 16'd4}) begin
            bad++;
            $display("FAIL gap_xfer: got busy=%b vld=%b sig=%h cnt=%0d want busy=0 vld=0 sig=0e1f cnt=4",
                     busy, sig_vld, sig, cnt);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        len   = 16'd5;
        tick();
        start    = 1'b0;
        resp_vld = 1'b1;
        resp     = 6'h00;
        tick();
        // Second capture with a competing START that must not restart the session.
        start = 1'b1;
        len   = 16'd1;
        tick();
        start = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b1, 1'b0, 16'hCF9F, 16'd2}) begin
            bad++;
            $display("FAIL abort_run_start_ignored: got busy=%b vld=%b sig=%h cnt=%0d want busy=1 vld=0 sig=cf9f cnt=2",
                     busy, sig_vld, sig, cnt);
        end
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        resp_vld = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b0, 1'b0, 16'hCF9F, 16'd2}) begin
            bad++;
            $display("FAIL abort_run: got busy=%b vld=%b sig=%h cnt=%0d want busy=0 vld=0 sig=cf9f cnt=2",
                     busy, sig_vld, sig, cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({busy, sig_vld} !== 2'b00) begin
                bad++;
                $display("FAIL abort_run_after[%0d]: got busy=%b vld=%b want 0 0", i, busy, sig_vld);
            end
        end
        // START and ABORT together in IDLE: START is taken.
        start = 1'b1;
        abort = 1'b1;
        len   = 16'd0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b1, 1'b1, 16'hFFFF, 16'd0}) begin
            bad++;
            $display("FAIL abort_idle_start: got busy=%b vld=%b sig=%h cnt=%0d want busy=1 vld=1 sig=ffff cnt=0",
                     busy, sig_vld, sig, cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, sig_vld} !== 2'b00) begin
            bad++;
            $display("FAIL abort_hold: got busy=%b vld=%b want busy=0 vld=0", busy, sig_vld);
        end
        tick();
        total++;
        if (sig_vld !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold_after: got vld=%b want 0", sig_vld);
        end
    endtask

    task automatic test_async_rst();
        start = 1'b1;
        len   = 16'd5;
        tick();
        start    = 1'b0;
        resp_vld = 1'b1;
        resp     = 6'h3F;
        tick();
        resp_vld = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, sig_vld, sig, cnt} !== {1'b0, 1'b0, 16'hFFFF, 16'd0}) begin
            bad++;
            $display("FAIL async_rst: got busy=%b vld=%b sig=%h cnt=%0d want busy=0 vld=0 sig=ffff cnt=0",
                     busy, sig_vld, sig, cnt);
        end
        #2;
        rst = 1'b0;
        test_len1(6'h3F, 16'hEFE0);
    endtask

    initial begin
        test_reset();
        test_len1(6'h00, 16'hEFDF);
        test_len1(6'h3F, 16'hEFE0);
        test_len0();
        test_gapped();
        test_abort();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
